lsu_mem_master: RTL and testbench
=================================

// Module: lsu_mem_master
// PURPOSE
//  Initiator side of the data-memory request interface: turns RV32I load/store ops from the MEM stage into
//  one-cycle mem_request transactions (we_re, mask, word address, data). Aligns and extends returned load data.
//  Sits between the pipeline MEM stage and data_mem_top; the pipeline holds the MEM stage until lsu_done.
// PARAMETERS
//  ADDR_W      8  word-address width driven on mem_address
//  MEM_RD_LAT  1  cycles from the mem_request cycle to valid mem_data_out; legal range 1..4
// PORTS
//  clk            in   1       clock; all state updates on rising edge
//  rst            in   1       asynchronous, active-low reset
//  lsu_valid      in   1       op presented; accepted when lsu_valid && lsu_ready
//  lsu_is_store   in   1       1 = store, 0 = load
//  lsu_funct3     in   3       RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  lsu_addr       in   32      effective byte address
//  lsu_wdata      in   32      store data (rs2)
//  lsu_ready      out  1       high in IDLE only
//  lsu_done       out  1       one-cycle completion pulse
//  lsu_fault      out  1       one-cycle pulse, coincident with lsu_done, for a faulted op
//  lsu_rdata      out  32      load result; held until the next load completes
//  mem_request    out  1       one-cycle request strobe
//  mem_we_re      out  1       1 = write, 0 = read; valid with mem_request
//  mem_mask       out  4       byte write enables; 0 for loads
//  mem_address    out  ADDR_W  lsu_addr[ADDR_W+1:2]
//  mem_data_in    out  32      write data, lane-replicated; 0 for loads
//  mem_data_out   in   32      read word from memory
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; lsu_done, lsu_fault, lsu_rdata and all mem_* outputs are 0.
//    lsu_ready=1 once in IDLE. A reset mid-op aborts it: no lsu_done, mem_request drops at once.
//  - FSM IDLE -> REQ -> (load) WAIT -> IDLE; (store) REQ -> IDLE; (fault) IDLE -> IDLE.
//  - Accept in cycle 0. Cycle 1 (REQ): mem_request=1 with registered we_re, mask, address, data.
//    All mem_* outputs are 0 in every cycle without mem_request.
//  - Store: lsu_done pulses in cycle 2.
//  - Load: WAIT counts MEM_RD_LAT cycles. mem_data_out is sampled in cycle 1+MEM_RD_LAT.
//    lsu_rdata updates and lsu_done pulses in cycle 2+MEM_RD_LAT (3 at default).
//  - lsu_ready=1 in the lsu_done cycle, so back-to-back ops are accepted with no bubble.
//  - Fault: funct3 in {011,110,111}, funct3 with lsu_is_store=1 in {100,101}, H/HU with addr[0]=1, W with addr[1:0]!=0.
//    No memory request is issued. lsu_done=lsu_fault=1 in cycle 1. lsu_rdata unchanged.
//  - Store lanes (o = addr[1:0]):
//    - SB: mask=4'b0001<<o, data={4{wdata[7:0]}}
//    - SH: mask=4'b0011<<o, data={2{wdata[15:0]}}
//    - SW: mask=4'b1111, data=wdata
//  - Load extract (o = addr[1:0]):
//    - LB/LBU: byte o, sign-/zero-extended
//    - LH/LHU: halfword o[1], sign-/zero-extended
//    - LW: full word
//  - lsu_valid in a non-IDLE state is ignored; the captured op is unaffected by input changes after accept.
// CONFIGURATION
//  LSU_RANGE_CHECK_EN defined: an op with lsu_addr[31:ADDR_W+2] != 0 is also a fault (same timing, no request).
//  Not defined: upper address bits are ignored; the address wraps modulo 2^(ADDR_W+2) bytes.
// TESTING
//  SW addr=0x10 wdata=0xDEADBEEF -> cycle1: req=1 we_re=1 mask=1111 address=0x04 data=0xDEADBEEF; done cycle2
//  SB addr=0x13 wdata=0x000000A5 -> mask=1000 data=0xA5A5A5A5; SH addr=0x12 -> mask=1100
//  LB addr=0x01, mem word 0x12348000 -> rdata=0xFFFFFF80 in cycle3; LHU addr=0x02 -> rdata=0x00001234
//  LW addr=0x06 -> fault+done cycle1, mem_request never asserted, rdata unchanged
//  Back-to-back SW then LW with lsu_valid held high -> second accept in store's done cycle; rst low in WAIT -> no done
//  MEM_RD_LAT=3, LW -> done in cycle 5; with LSU_RANGE_CHECK_EN, LW addr=0x400 -> fault, no request

Source files
------------

// File: rtl/lsu_mem_master.sv
// Load/store initiator: turns MEM-stage RV32I loads/stores into one-cycle memory requests and aligns load data.
// Optional feature: define LSU_RANGE_CHECK_EN to fault ops whose byte address exceeds the ADDR_W word space.
module lsu_mem_master #(
    parameter int ADDR_W     = 8,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_valid,
    input  logic              lsu_is_store,
    input  logic [2:0]        lsu_funct3,
    input  logic [31:0]       lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_ready,
    output logic              lsu_done,
    output logic              lsu_fault,
    output logic [31:0]       lsu_rdata,
    output logic              mem_request,
    output logic              mem_we_re,
    output logic [3:0]        mem_mask,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    input  logic [31:0]       mem_data_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [2:0] LAT_C = 3'(MEM_RD_LAT);

    logic [1:0]        state_r;
    logic [2:0]        lat_cnt_r;
    logic              is_store_r;
    logic [2:0]        funct3_r;
    logic [1:0]        offset_r;
    logic              done_r;
    logic              fault_r;
    logic [31:0]       rdata_r;
    logic              req_r;
    logic              we_r;
    logic [3:0]        mask_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic              range_bad_s;

`ifdef LSU_RANGE_CHECK_EN
    assign range_bad_s = |lsu_addr[31:ADDR_W+2];
`else
    // Upper address bits are intentionally dropped: the address wraps.
    logic unused_addr_hi_s;
    assign unused_addr_hi_s = ^lsu_addr[31:ADDR_W+2];
    assign range_bad_s      = 1'b0;
`endif

    function automatic logic op_fault(input logic is_store, input logic [2:0] f3,
                                      input logic [1:0] off, input logic range_bad);
        logic f;
        case (f3)
            3'b000:  f = 1'b0;
            3'b001:  f = off[0];
            3'b010:  f = (off != 2'b00);
            3'b100:  f = is_store;
            3'b101:  f = is_store | off[0];
            default: f = 1'b1;
        endcase
        return f | range_bad;
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // Op sequencing, memory request registers and load result capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            lat_cnt_r  <= 3'd0;
            is_store_r <= 1'b0;
            funct3_r   <= 3'd0;
            offset_r   <= 2'd0;
            done_r     <= 1'b0;
            fault_r    <= 1'b0;
            rdata_r    <= 32'd0;
            req_r      <= 1'b0;
            we_r       <= 1'b0;
            mask_r     <= 4'd0;
            addr_r     <= '0;
            wdata_r    <= 32'd0;
        end else begin
            done_r  <= 1'b0;
            fault_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (lsu_valid) begin
                        if (op_fault(lsu_is_store, lsu_funct3, lsu_addr[1:0], range_bad_s)) begin
                            done_r  <= 1'b1;
                            fault_r <= 1'b1;
                        end else begin
                            state_r    <= REQ;
                            is_store_r <= lsu_is_store;
                            funct3_r   <= lsu_funct3;
                            offset_r   <= lsu_addr[1:0];
                            req_r      <= 1'b1;
                            we_r       <= lsu_is_store;
                            mask_r     <= lsu_is_store ? store_mask(lsu_funct3[1:0], lsu_addr[1:0]) : 4'd0;
                            addr_r     <= lsu_addr[ADDR_W+1:2];
                            wdata_r    <= lsu_is_store ? store_lanes(lsu_funct3[1:0], lsu_wdata) : 32'd0;
                        end
                    end
                end
                REQ: begin
                    req_r   <= 1'b0;
                    we_r    <= 1'b0;
                    mask_r  <= 4'd0;
                    addr_r  <= '0;
                    wdata_r <= 32'd0;
                    if (is_store_r) begin
                        state_r <= IDLE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r   <= WAIT;
                        lat_cnt_r <= 3'd1;
                    end
                end
                WAIT: begin
                    // The count reaches MEM_RD_LAT in the cycle the read word is valid.
                    if (lat_cnt_r == LAT_C) begin
                        rdata_r <= load_extract(funct3_r, offset_r, mem_data_out);
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + 3'd1;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign lsu_ready   = (state_r == IDLE);
    assign lsu_done    = done_r;
    assign lsu_fault   = fault_r;
    assign lsu_rdata   = rdata_r;
    assign mem_request = req_r;
    assign mem_we_re   = we_r;
    assign mem_mask    = mask_r;
    assign mem_address = addr_r;
    assign mem_data_in = wdata_r;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed and random ops against a latency-accurate memory and a scoreboard.
module tb_lsu_mem_master;
    localparam int ADDR_W = 8;
    localparam int LAT    = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              lsu_valid = 1'b0;
    logic              lsu_is_store = 1'b0;
    logic [2:0]        lsu_funct3 = 3'd0;
    logic [31:0]       lsu_addr = 32'd0;
    logic [31:0]       lsu_wdata = 32'd0;
    logic              lsu_ready, lsu_done, lsu_fault;
    logic [31:0]       lsu_rdata;
    logic              mem_request, mem_we_re;
    logic [3:0]        mem_mask;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data_in, mem_data_out;

    always #5 clk = ~clk;

    lsu_mem_master #(.ADDR_W(ADDR_W), .MEM_RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .lsu_is_store(lsu_is_store),
        .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_ready(lsu_ready), .lsu_done(lsu_done), .lsu_fault(lsu_fault), .lsu_rdata(lsu_rdata),
        .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_mask(mem_mask),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          cyc;
    } done_t;

    done_t       done_q[$];
    logic [44:0] req_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_acc = 0;
    logic [31:0] exp_rdata = 32'd0;
    logic [31:0] ref_mem [0:255];
    logic [31:0] dev_mem [0:255];
    logic [31:0] pipe_d [LAT];
    logic        pipe_v [LAT];

    function automatic logic [31:0] seed(input int i);
        return 32'h1234_8000 ^ (32'(i) * 32'h0101_0107);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory device: reseeded while in reset, read data valid only LAT cycles after the request.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) dev_mem[i] <= seed(i);
            for (int i = 0; i < LAT; i++) pipe_v[i] <= 1'b0;
        end else begin
            if (mem_request && mem_we_re)
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) dev_mem[mem_address][8*b +: 8] <= mem_data_in[8*b +: 8];
            pipe_v[0] <= mem_request && !mem_we_re;
            pipe_d[0] <= dev_mem[mem_address];
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end
    assign mem_data_out = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hBAD0_BAD0;

    function automatic logic ref_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
        logic bad;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)
            || (st && (f3 == 3'b100 || f3 == 3'b101))
            || ((f3 == 3'b001 || f3 == 3'b101) && a[0])
            || ((f3 == 3'b010) && (a[1:0] != 2'b00));
`ifdef LSU_RANGE_CHECK_EN
        bad = bad || (a[31:ADDR_W+2] != 22'd0);
`endif
        return bad;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] sb, sh;
        sb = w >> {a[1:0], 3'b000};
        sh = w >> {a[1], 4'b0000};
        case (f3)
            3'b000:  return {{24{sb[7]}}, sb[7:0]};
            3'b100:  return {24'd0, sb[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reseed_ref();
        for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
        exp_rdata = 32'd0;
    endtask

    // Presents one op when the DUT is ready and records what it must produce; returns just after the accept edge.
    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int          n;
        int          idx;
        logic [3:0]  m;
        logic [31:0] dd;
        done_t       d;
        n = 0;
        @(negedge clk);
        while (!lsu_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {63'd0, lsu_ready}, 64'd1);
        if (!lsu_ready) return;
        lsu_valid = 1'b1; lsu_is_store = st; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
        idx = int'(a[ADDR_W+1:2]);
        if (ref_fault(st, f3, a)) begin
            d = '{rdata: exp_rdata, fault: 1'b1, cyc: cyc + 1};
        end else if (st) begin
            case (f3)
                3'b000: begin
                    m = 4'b0001 << a[1:0]; dd = {4{wd[7:0]}};
                    ref_mem[idx][{a[1:0], 3'b000} +: 8] = wd[7:0];
                end
                3'b001: begin
                    m = 4'b0011 << a[1:0]; dd = {2{wd[15:0]}};
                    ref_mem[idx][{a[1], 4'b0000} +: 16] = wd[15:0];
                end
                default: begin
                    m = 4'b1111; dd = wd; ref_mem[idx] = wd;
                end
            endcase
            req_q.push_back({1'b1, m, a[ADDR_W+1:2], dd});
            d = '{rdata: exp_rdata, fault: 1'b0, cyc: cyc + 2};
        end else begin
            req_q.push_back({1'b0, 4'd0, a[ADDR_W+1:2], 32'd0});
            exp_rdata = ref_load(f3, a, ref_mem[idx]);
            d = '{rdata: exp_rdata, fault: 1'b0, cyc: cyc + 2 + LAT};
        end
        done_q.push_back(d);
        last_acc = cyc + 1;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        lsu_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Output monitor: completions and memory requests are checked against the scoreboard every cycle.
    always @(negedge clk) begin
        done_t       d;
        logic [44:0] r;
        if (lsu_done) begin
            tests++;
            assert (done_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_done observed=1 expected=0 cyc=%0d", cyc);
            end
            if (done_q.size() != 0) begin
                d = done_q.pop_front();
                tests++;
                assert (lsu_fault === d.fault && lsu_rdata === d.rdata && cyc == d.cyc) else begin
                    fails++;
                    $error("FAIL done observed fault=%b rdata=%h cyc=%0d expected fault=%b rdata=%h cyc=%0d",
                           lsu_fault, lsu_rdata, cyc, d.fault, d.rdata, d.cyc);
                end
            end
        end else begin
            tests++;
            assert (lsu_fault === 1'b0) else begin
                fails++;
                $error("FAIL fault_without_done observed=%b expected=0", lsu_fault);
            end
        end
        if (mem_request) begin
            tests++;
            assert (req_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_request observed=1 expected=0 cyc=%0d", cyc);
            end
            if (req_q.size() != 0) begin
                r = req_q.pop_front();
                tests++;
                assert ({mem_we_re, mem_mask, mem_address, mem_data_in} === r) else begin
                    fails++;
                    $error("FAIL request observed=%h expected=%h",
                           {mem_we_re, mem_mask, mem_address, mem_data_in}, r);
                end
            end
        end else begin
            tests++;
            assert ({mem_we_re, mem_mask, mem_address, mem_data_in} === 45'd0) else begin
                fails++;
                $error("FAIL idle_bus observed=%h expected=0", {mem_we_re, mem_mask, mem_address, mem_data_in});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        reseed_ref();
        repeat (2) @(negedge clk);
        chk("reset_ready", {63'd0, lsu_ready}, 64'd1);
        chk("reset_outs", {lsu_done, lsu_fault, mem_request, lsu_rdata}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        do_op(1'b1, 3'b000, 32'h13, 32'h0000_00A5);
        do_op(1'b1, 3'b001, 32'h12, 32'h0000_BEEF);
        idle(3);
        do_op(1'b0, 3'b000, 32'h01, 32'd0);
        idle(3);
        chk("lb_example", {32'd0, lsu_rdata}, {32'd0, 32'hFFFF_FF80});
        do_op(1'b0, 3'b101, 32'h02, 32'd0);
        idle(3);
        chk("lhu_example", {32'd0, lsu_rdata}, {32'd0, 32'h0000_1234});
        do_op(1'b0, 3'b010, 32'h06, 32'd0);
        idle(2);
        chk("fault_keeps_rdata", {32'd0, lsu_rdata}, {32'd0, 32'h0000_1234});
        do_op(1'b0, 3'b100, 32'h13, 32'd0);
        do_op(1'b0, 3'b001, 32'h12, 32'd0);
        do_op(1'b0, 3'b010, 32'h10, 32'd0);
        idle(3);
        chk("merged_word", {32'd0, lsu_rdata}, {32'd0, 32'hBEEF_BEEF});
        do_op(1'b0, 3'b011, 32'h00, 32'd0);
        do_op(1'b1, 3'b100, 32'h04, 32'h55);
        do_op(1'b1, 3'b001, 32'h05, 32'h77);
        do_op(1'b0, 3'b101, 32'h03, 32'd0);
        do_op(1'b0, 3'b010, 32'h400, 32'd0);
        idle(3);

        do_op(1'b1, 3'b010, 32'h20, 32'hCAFE_F00D);
        a1 = last_acc;
        do_op(1'b0, 3'b010, 32'h20, 32'd0);
        chk("b2b_accept_gap", 64'(last_acc - a1), 64'd2);
        for (int i = 0; i < 30; i++)
            do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)), $urandom);
        idle(4);

        do_op(1'b0, 3'b010, 32'h08, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        done_q.delete();
        req_q.delete();
        reseed_ref();
        #1 chk("rst_in_wait", {lsu_done, lsu_ready, lsu_rdata}, {30'd0, 1'b0, 1'b1, 32'd0});
        idle(2);
        rst = 1'b1;
        idle(3);

        do_op(1'b1, 3'b010, 32'h0C, 32'h1111_2222);
        #2 rst = 1'b0;
        #1 chk("rst_drops_req", {mem_request, mem_mask}, 64'd0);
        done_q.delete();
        req_q.delete();
        reseed_ref();
        idle(2);
        rst = 1'b1;
        do_op(1'b0, 3'b010, 32'h0C, 32'd0);
        idle(4);
        chk("queues_drained", 64'(done_q.size() + req_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
